snoop_responder: RTL and testbench

- Responder side of the shared-bus snoop protocol. The cache model's bus-operation issuer drives a bus operation plus address; this block answers with HIT, HITM or NOHIT.
- Holds a direct-mapped tag/MESI directory for the local cache and applies the MESI snoop transitions to it.
- On HITM, issues the modified-line writeback onto the bus.
- Sits between the system bus model and the local cache directory; the local cache installs lines through a fill port.

---
 rtl/snoop_responder.sv | 162 ++++++++++++++++
 tb/tb_snoop_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_responder.sv
// snoop_responder: MESI snoop responder with a direct-mapped directory, modified-line writeback and result counters
module snoop_responder #(
  parameter int A_SIZE     = 32,
  parameter int LINE_BYTES = 64,
  parameter int NUM_SETS   = 256,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [A_SIZE-1:0] req_addr,
  output logic              snoop_valid,
  output logic [1:0]        snoop_result,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [A_SIZE-1:0] wb_addr,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic [A_SIZE-1:0] fill_addr,
  input  logic [1:0]        fill_mesi,
  output logic              proto_err,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  hitm_cnt,
  output logic [CNT_W-1:0]  nohit_cnt
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = A_SIZE - OFF_W - IDX_W;
  localparam int LA_W  = A_SIZE - OFF_W;
  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;
  localparam logic [1:0] R_HIT = 2'd0, R_HITM = 2'd1, R_NOHIT = 2'd2;
  localparam logic [2:0] OP_READ = 3'd1, OP_WRITE = 3'd2, OP_INV = 3'd3, OP_RWIM = 3'd4;
  typedef enum logic [1:0] {IDLE, LOOKUP, RESP, WB} state_t;
  state_t            state_q, state_d;
  logic              rdy_q;
  logic [2:0]        op_q, op_d;
  logic [LA_W-1:0]   addr_q, addr_d;
  logic [1:0]        res_q, res_d;
  logic [1:0]        nst_q, nst_d;
  logic              upd_q, upd_d;
  logic              perr_q, perr_d;
  logic              proto_err_q, proto_err_d;
  logic [A_SIZE-1:0] wb_addr_q, wb_addr_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d, hitm_cnt_q, hitm_cnt_d, nohit_cnt_q, nohit_cnt_d;
  logic [TAG_W-1:0]  tag_q [NUM_SETS];
  logic [1:0]        mesi_q [NUM_SETS];
  logic              dir_we, tag_we;
  logic [IDX_W-1:0]  dir_idx, l_idx;
  logic [TAG_W-1:0]  l_tag;
  logic [1:0]        dir_mesi, cur, lk_res, lk_st;
  logic              lk_err;
  logic              unused;
  assign unused = ^{req_addr[OFF_W-1:0], fill_addr[OFF_W-1:0]};
  assign l_idx  = addr_q[IDX_W-1:0];
  assign l_tag  = addr_q[LA_W-1 -: TAG_W];
  // tag array needs no reset: a line is only valid through its MESI state
  always_ff @(posedge clk)
    if (tag_we) tag_q[dir_idx] <= fill_addr[A_SIZE-1 -: TAG_W];
  // MESI array, all lines invalid out of reset
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < NUM_SETS; i++) mesi_q[i] <= ST_I;
    else if (dir_we) mesi_q[dir_idx] <= dir_mesi;
  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      op_q        <= '0;
      addr_q      <= '0;
      res_q       <= R_NOHIT;
      nst_q       <= ST_I;
      upd_q       <= 1'b0;
      perr_q      <= 1'b0;
      proto_err_q <= 1'b0;
      wb_addr_q   <= '0;
      hit_cnt_q   <= '0;
      hitm_cnt_q  <= '0;
      nohit_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= 1'b1;
      op_q        <= op_d;
      addr_q      <= addr_d;
      res_q       <= res_d;
      nst_q       <= nst_d;
      upd_q       <= upd_d;
      perr_q      <= perr_d;
      proto_err_q <= proto_err_d;
      wb_addr_q   <= wb_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      hitm_cnt_q  <= hitm_cnt_d;
      nohit_cnt_q <= nohit_cnt_d;
    end
  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (req_valid && req_ready) ? LOOKUP : IDLE;
      LOOKUP:  state_d = RESP;
      RESP:    state_d = (res_q == R_HITM) ? WB : IDLE;
      WB:      state_d = wb_ready ? IDLE : WB;
      default: state_d = IDLE;
    endcase
  end
  // snoop rules applied to the looked-up line; a miss behaves as state I
  always_comb begin
    cur    = (mesi_q[l_idx] != ST_I && tag_q[l_idx] == l_tag) ? mesi_q[l_idx] : ST_I;
    lk_res = R_NOHIT;
    lk_st  = cur;
    lk_err = 1'b0;
    case (op_q)
      OP_READ: begin
        lk_res = cur == ST_M ? R_HITM : cur == ST_I ? R_NOHIT : R_HIT;
        lk_st  = cur == ST_I ? ST_I : ST_S;
      end
      OP_WRITE: lk_err = cur == ST_M || cur == ST_E;
      OP_INV: begin
        lk_res = cur == ST_S ? R_HIT : R_NOHIT;
        lk_st  = cur == ST_S ? ST_I : cur;
        lk_err = cur == ST_M || cur == ST_E;
      end
      OP_RWIM: begin
        lk_res = cur == ST_M ? R_HITM : cur == ST_I ? R_NOHIT : R_HIT;
        lk_st  = ST_I;
      end
      default: lk_err = 1'b1;
    endcase
  end
  // datapath: capture request, latch lookup, commit on the response edge; fills only land in IDLE
  always_comb begin
    op_d        = (state_q == IDLE && req_valid && req_ready) ? req_op : op_q;
    addr_d      = (state_q == IDLE && req_valid && req_ready) ? req_addr[A_SIZE-1:OFF_W] : addr_q;
    res_d       = state_q == LOOKUP ? lk_res : res_q;
    nst_d       = state_q == LOOKUP ? lk_st : nst_q;
    upd_d       = state_q == LOOKUP ? lk_st != cur : upd_q;
    perr_d      = state_q == LOOKUP ? lk_err : perr_q;
    proto_err_d = proto_err_q | (state_q == RESP && perr_q);
    wb_addr_d   = (state_q == RESP && res_q == R_HITM) ? {addr_q, {OFF_W{1'b0}}} : wb_addr_q;
    hit_cnt_d   = (state_q == RESP && res_q == R_HIT && hit_cnt_q != '1) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
    hitm_cnt_d  = (state_q == RESP && res_q == R_HITM && hitm_cnt_q != '1) ? hitm_cnt_q + CNT_W'(1) : hitm_cnt_q;
    nohit_cnt_d = (state_q == RESP && res_q == R_NOHIT && nohit_cnt_q != '1) ? nohit_cnt_q + CNT_W'(1) : nohit_cnt_q;
    tag_we      = fill_valid && fill_ready;
    dir_we      = tag_we || (state_q == RESP && upd_q);
    dir_idx     = state_q == RESP ? l_idx : fill_addr[OFF_W +: IDX_W];
    dir_mesi    = state_q == RESP ? nst_q : fill_mesi;
  end
  // outputs decoded from state
  always_comb begin
    req_ready    = rdy_q && state_q == IDLE;
    fill_ready   = rdy_q && state_q == IDLE && !req_valid;
    snoop_valid  = state_q == RESP;
    snoop_result = res_q;
    wb_valid     = state_q == WB;
    wb_addr      = wb_addr_q;
    proto_err    = proto_err_q;
    hit_cnt      = hit_cnt_q;
    hitm_cnt     = hitm_cnt_q;
    nohit_cnt    = nohit_cnt_q;
  end
endmodule

// File: tb/tb_snoop_responder.sv
// tb_snoop_responder: directed and randomized checks of snoop_responder against a directory model
module tb_snoop_responder;
  localparam int AW = 32;
  localparam int CW = 4;
  logic clk = 0, reset_n = 0;
  logic req_valid = 0, req_ready, snoop_valid, wb_valid, wb_ready = 0, fill_valid = 0, fill_ready, proto_err;
  logic [2:0] req_op = 0;
  logic [AW-1:0] req_addr = 0, wb_addr, fill_addr = 0;
  logic [1:0] snoop_result, fill_mesi = 0;
  logic [CW-1:0] hit_cnt, hitm_cnt, nohit_cnt;
  int tests = 0, fails = 0;
  int m_tag [256];
  int m_st [256];
  int m_cnt [3];
  bit m_err;
  always #5 clk = ~clk;
  snoop_responder #(.A_SIZE(AW), .LINE_BYTES(64), .NUM_SETS(256), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .snoop_valid(snoop_valid), .snoop_result(snoop_result), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_addr(wb_addr), .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_addr(fill_addr), .fill_mesi(fill_mesi), .proto_err(proto_err), .hit_cnt(hit_cnt),
    .hitm_cnt(hitm_cnt), .nohit_cnt(nohit_cnt));
  function automatic void m_reset();
    for (int i = 0; i < 256; i++) m_st[i] = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_err = 0;
  endfunction
  function automatic void m_fill(logic [31:0] a, int st);
    m_tag[a[13:6]] = int'(a[31:14]);
    m_st[a[13:6]] = st;
  endfunction
  // expected result of a snoop (0 HIT, 1 HITM, 2 NOHIT), updating the model directory, counters and error flag
  function automatic logic [1:0] m_snoop(int op, logic [31:0] a);
    int idx = int'(a[13:6]);
    int cur = (m_st[idx] != 0 && m_tag[idx] == int'(a[31:14])) ? m_st[idx] : 0;
    int ns = cur;
    int res = 2;
    if (op == 1) begin
      if (cur == 3) begin res = 1; ns = 1; end
      else if (cur != 0) begin res = 0; ns = 1; end
    end else if (op == 2) begin
      if (cur >= 2) m_err = 1;
    end else if (op == 3) begin
      if (cur == 1) begin res = 0; ns = 0; end
      else if (cur >= 2) m_err = 1;
    end else if (op == 4) begin
      if (cur == 3) res = 1;
      else if (cur != 0) res = 0;
      ns = 0;
    end else m_err = 1;
    if (cur != 0) m_st[idx] = ns;
    if (m_cnt[res] < (1 << CW) - 1) m_cnt[res]++;
    return 2'(res);
  endfunction
  task automatic snoop(input logic [2:0] op, input logic [31:0] a, input int hold, output logic [1:0] res,
                       output bit lat_ok, output bit wb_seen, output logic [31:0] wba, output bit wb_ok);
    int n = 0;
    bit s1;
    @(negedge clk); req_valid = 1; req_op = op; req_addr = a;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk); s1 = snoop_valid || req_ready;
    @(negedge clk); lat_ok = !s1 && snoop_valid && !req_ready && n < 100; res = snoop_result;
    @(negedge clk); wb_seen = wb_valid; wba = wb_addr; wb_ok = 1;
    if (wb_valid) begin
      repeat (hold) begin if (!wb_valid || req_ready) wb_ok = 0; @(negedge clk); end
      wb_ready = 1; @(posedge clk); #1 wb_ready = 0;
      @(negedge clk); if (wb_valid || !req_ready) wb_ok = 0;
    end
  endtask
  task automatic fill(input logic [31:0] a, input logic [1:0] m, output bit ok);
    int n = 0;
    @(negedge clk); fill_valid = 1; fill_addr = a; fill_mesi = m;
    while (!fill_ready && n < 100) begin @(negedge clk); n++; end
    ok = n < 100;
    @(posedge clk); #1 fill_valid = 0;
    m_fill(a, int'(m));
  endtask
  task automatic test_reset();
    reset_n = 0; req_valid = 1; req_op = 1;
    repeat (3) @(negedge clk);
    tests++; if (req_ready !== 0 || snoop_valid !== 0 || wb_valid !== 0 || fill_ready !== 0) begin
      fails++; $display("FAIL reset_ctrl: ready=%b sv=%b wbv=%b fr=%b want 0000", req_ready, snoop_valid, wb_valid, fill_ready); end
    tests++; if (snoop_result !== 2'd2 || wb_addr !== 0 || proto_err !== 0) begin
      fails++; $display("FAIL reset_data: res=%0d wba=%h perr=%b want 2 0 0", snoop_result, wb_addr, proto_err); end
    tests++; if (hit_cnt !== 0 || hitm_cnt !== 0 || nohit_cnt !== 0) begin
      fails++; $display("FAIL reset_cnt: %0d %0d %0d want 0 0 0", hit_cnt, hitm_cnt, nohit_cnt); end
    req_valid = 0; reset_n = 1; m_reset();
    @(posedge clk); @(negedge clk);
    tests++; if (req_ready !== 1) begin fails++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask
  task automatic test_read_miss();
    logic [1:0] r, e; logic [31:0] wa; bit lat, ws, wo;
    snoop(1, 32'h0000_1040, 0, r, lat, ws, wa, wo); e = m_snoop(1, 32'h0000_1040);
    tests++; if (r !== e || !lat || ws) begin fails++; $display("FAIL read_miss: res=%0d lat=%b wb=%b want %0d 1 0", r, lat, ws, e); end
    tests++; if (nohit_cnt !== CW'(m_cnt[2])) begin fails++; $display("FAIL read_miss_cnt: got %0d want %0d", nohit_cnt, m_cnt[2]); end
  endtask
  task automatic test_hitm_wb();
    logic [1:0] r, e; logic [31:0] wa; bit lat, ws, wo, ok;
    fill(32'h0000_1040, 3, ok);
    snoop(1, 32'h0000_1044, 3, r, lat, ws, wa, wo); e = m_snoop(1, 32'h0000_1044);
    tests++; if (r !== e || !lat) begin fails++; $display("FAIL hitm_res: res=%0d lat=%b want %0d 1", r, lat, e); end
    tests++; if (!ws || wa !== 32'h0000_1040 || !wo) begin
      fails++; $display("FAIL hitm_wb: seen=%b addr=%h stall_ok=%b want 1 00001040 1", ws, wa, wo); end
    tests++; if (hitm_cnt !== CW'(m_cnt[1])) begin fails++; $display("FAIL hitm_cnt: got %0d want %0d", hitm_cnt, m_cnt[1]); end
    snoop(1, 32'h0000_1040, 0, r, lat, ws, wa, wo); e = m_snoop(1, 32'h0000_1040);
    tests++; if (r !== e || ws) begin fails++; $display("FAIL hitm_then_hit: res=%0d wb=%b want %0d 0", r, ws, e); end
  endtask
  task automatic test_rwim();
    logic [1:0] r, e; logic [31:0] wa; bit lat, ws, wo, ok;
    fill(32'h2000_0000, 2, ok);
    snoop(4, 32'h2000_0000, 0, r, lat, ws, wa, wo); e = m_snoop(4, 32'h2000_0000);
    tests++; if (r !== e || ws) begin fails++; $display("FAIL rwim_e: res=%0d wb=%b want %0d 0", r, ws, e); end
    snoop(1, 32'h2000_0000, 0, r, lat, ws, wa, wo); e = m_snoop(1, 32'h2000_0000);
    tests++; if (r !== e) begin fails++; $display("FAIL rwim_after_read: res=%0d want %0d", r, e); end
  endtask
  task automatic test_invalidate();
    logic [1:0] r, e; logic [31:0] wa; bit lat, ws, wo, ok;
    fill(32'h0000_3000, 1, ok);
    snoop(3, 32'h0000_3000, 0, r, lat, ws, wa, wo); e = m_snoop(3, 32'h0000_3000);
    tests++; if (r !== e || proto_err !== 0) begin fails++; $display("FAIL inv_s: res=%0d perr=%b want %0d 0", r, proto_err, e); end
    fill(32'h0000_3000, 3, ok);
    snoop(3, 32'h0000_3000, 0, r, lat, ws, wa, wo); e = m_snoop(3, 32'h0000_3000);
    tests++; if (r !== e || proto_err !== m_err) begin fails++; $display("FAIL inv_m: res=%0d perr=%b want %0d %b", r, proto_err, e, m_err); end
    snoop(1, 32'h0000_3000, 1, r, lat, ws, wa, wo); e = m_snoop(1, 32'h0000_3000);
    tests++; if (r !== e || !ws || wa !== 32'h0000_3000) begin
      fails++; $display("FAIL inv_m_kept: res=%0d wb=%b addr=%h want %0d 1 00003000", r, ws, wa, e); end
  endtask
  task automatic test_collision();
    logic [1:0] r, e; logic [31:0] wa; bit lat, ws, wo;
    int n = 0;
    @(negedge clk); req_valid = 1; req_op = 1; req_addr = 32'h0000_1040;
    fill_valid = 1; fill_addr = 32'h0000_5080; fill_mesi = 3;
    #1;
    tests++; if (fill_ready !== 0 || req_ready !== 1) begin
      fails++; $display("FAIL collide_ready: fill_ready=%b req_ready=%b want 0 1", fill_ready, req_ready); end
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk); @(negedge clk);
    e = m_snoop(1, 32'h0000_1040);
    tests++; if (snoop_valid !== 1 || snoop_result !== e) begin
      fails++; $display("FAIL collide_snoop: sv=%b res=%0d want 1 %0d", snoop_valid, snoop_result, e); end
    while (!fill_ready && n < 100) begin @(negedge clk); n++; end
    tests++; if (n != 1) begin fails++; $display("FAIL collide_fill_wait: waited %0d cycles want 1", n); end
    @(posedge clk); #1 fill_valid = 0;
    m_fill(32'h0000_5080, 3);
    snoop(1, 32'h0000_5080, 0, r, lat, ws, wa, wo); e = m_snoop(1, 32'h0000_5080);
    tests++; if (r !== e || !ws || wa !== 32'h0000_5080 || !wo) begin
      fails++; $display("FAIL collide_filled: res=%0d wb=%b addr=%h want %0d 1 00005080", r, ws, wa, e); end
  endtask
  task automatic test_back_to_back();
    logic [1:0] e1, e2; bit ok, b1, b2;
    int n = 0;
    fill(32'h0000_9000, 3, ok);
    @(negedge clk); req_valid = 1; req_op = 1; req_addr = 32'h0000_9000;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk); b1 = req_ready;
    @(negedge clk); b1 = b1 | req_ready; e1 = m_snoop(1, 32'h0000_9000);
    tests++; if (snoop_result !== e1 || snoop_valid !== 1) begin
      fails++; $display("FAIL b2b_first: res=%0d sv=%b want %0d 1", snoop_result, snoop_valid, e1); end
    @(negedge clk); b1 = b1 | req_ready | !wb_valid;
    wb_ready = 1; @(posedge clk); #1 wb_ready = 0;
    @(negedge clk); b2 = req_ready;
    tests++; if (b1 || !b2) begin fails++; $display("FAIL b2b_ready: busy_ready=%b idle_ready=%b want 0 1", b1, b2); end
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk); @(negedge clk); e2 = m_snoop(1, 32'h0000_9000);
    tests++; if (snoop_result !== e2 || snoop_valid !== 1) begin
      fails++; $display("FAIL b2b_second: res=%0d sv=%b want %0d 1", snoop_result, snoop_valid, e2); end
  endtask
  task automatic test_reset_mid_wb();
    logic [1:0] r, e; logic [31:0] wa; bit lat, ws, wo, ok;
    int n = 0;
    fill(32'h0000_7000, 3, ok);
    @(negedge clk); req_valid = 1; req_op = 1; req_addr = 32'h0000_7000;
    @(posedge clk); #1 req_valid = 0;
    while (!wb_valid && n < 20) begin @(negedge clk); n++; end
    tests++; if (!wb_valid) begin fails++; $display("FAIL rst_wb_reach: wb_valid=%b want 1", wb_valid); end
    reset_n = 0; #1;
    tests++; if (wb_valid !== 0 || wb_addr !== 0 || req_ready !== 0 || proto_err !== 0) begin
      fails++; $display("FAIL rst_wb_out: wbv=%b wba=%h rdy=%b perr=%b want 0 0 0 0", wb_valid, wb_addr, req_ready, proto_err); end
    tests++; if (hit_cnt !== 0 || hitm_cnt !== 0 || nohit_cnt !== 0) begin
      fails++; $display("FAIL rst_wb_cnt: %0d %0d %0d want 0 0 0", hit_cnt, hitm_cnt, nohit_cnt); end
    @(negedge clk); reset_n = 1; m_reset();
    snoop(1, 32'h0000_7000, 0, r, lat, ws, wa, wo); e = m_snoop(1, 32'h0000_7000);
    tests++; if (r !== e || ws) begin fails++; $display("FAIL rst_wb_after: res=%0d wb=%b want %0d 0", r, ws, e); end
  endtask
  task automatic test_illegal_op();
    logic [1:0] r, e; logic [31:0] wa; bit lat, ws, wo;
    snoop(7, 32'h0000_1040, 0, r, lat, ws, wa, wo); e = m_snoop(7, 32'h0000_1040);
    tests++; if (r !== e || proto_err !== m_err || !lat) begin
      fails++; $display("FAIL illegal_op: res=%0d perr=%b lat=%b want %0d %b 1", r, proto_err, lat, e, m_err); end
  endtask
  task automatic test_random();
    logic [1:0] r, e; logic [31:0] a, wa; bit lat, ws, wo, ok;
    logic [17:0] tg [4];
    logic [7:0] ix [4];
    logic [2:0] op;
    int k;
    tg[0] = 18'h0; tg[1] = 18'h1; tg[2] = 18'h2AAAA; tg[3] = 18'h3FFFF;
    ix[0] = 8'h00; ix[1] = 8'h01; ix[2] = 8'h80; ix[3] = 8'hFF;
    for (int i = 0; i < 300; i++) begin
      a = {tg[$urandom_range(0, 3)], ix[$urandom_range(0, 3)], 6'($urandom_range(0, 63))};
      if ($urandom_range(0, 2) == 0) begin
        fill(a, 2'($urandom_range(0, 3)), ok);
        tests++; if (!ok) begin fails++; $display("FAIL rnd_fill_timeout: iter %0d", i); end
      end else begin
        k = $urandom_range(0, 9);
        op = k < 8 ? 3'(k % 4 + 1) : k == 8 ? 3'd0 : 3'($urandom_range(5, 7));
        snoop(op, a, $urandom_range(0, 2), r, lat, ws, wa, wo); e = m_snoop(int'(op), a);
        tests++; if (r !== e || !lat) begin fails++; $display("FAIL rnd_res: iter %0d op %0d addr %h res=%0d lat=%b want %0d 1", i, op, a, r, lat, e); end
        tests++; if (ws !== (e == 2'd1) || (ws && (wa !== {a[31:6], 6'd0} || !wo))) begin
          fails++; $display("FAIL rnd_wb: iter %0d seen=%b addr=%h ok=%b want %b %h", i, ws, wa, wo, e == 2'd1, {a[31:6], 6'd0}); end
        tests++; if (hit_cnt !== CW'(m_cnt[0]) || hitm_cnt !== CW'(m_cnt[1]) || nohit_cnt !== CW'(m_cnt[2]) || proto_err !== m_err) begin
          fails++; $display("FAIL rnd_stats: iter %0d cnt=%0d/%0d/%0d perr=%b want %0d/%0d/%0d %b", i, hit_cnt, hitm_cnt, nohit_cnt, proto_err, m_cnt[0], m_cnt[1], m_cnt[2], m_err); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_read_miss();
    test_hitm_wb();
    test_rwim();
    test_invalidate();
    test_collision();
    test_back_to_back();
    test_reset_mid_wb();
    test_illegal_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
